// File: rtl/cmd_entry.sv
// Command entry sequencer: debounces the set button, collects opcode and two
// register IDs from the switches, then offers the command over valid/ready.
module cmd_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REG_COUNT       = 8
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [3:0] inputs,
    input  logic       setButton,
    output logic [3:0] opCode,
    output logic [3:0] regID1,
    output logic [3:0] regID2,
    output logic [2:0] stage,
    output logic       cmdValid,
    input  logic       cmdReady,
    input  logic       opDone,
    output logic       badReg,
    output logic       busy
);

    typedef enum logic [2:0] {
        SEL_OP    = 3'd0,
        SEL_R1    = 3'd1,
        SEL_R2    = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       REG_LIMIT = (REG_COUNT >= 16) ? 5'd16 : 5'(REG_COUNT);

    // Register IDs at or above the register count are rejected.
    function automatic logic reg_id_ok(input logic [3:0] id);
        reg_id_ok = ({1'b0, id} < REG_LIMIT);
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             lat_op_s;
    logic             lat_r1_s;
    logic             lat_r2_s;
    logic             bad_s;
    logic             xfer_s;

    logic [3:0]       op_r;
    logic [3:0]       r1_r;
    logic [3:0]       r2_r;
    logic             valid_r;
    logic             bad_r;
    logic             busy_r;

    // Button synchronizer and debouncer; press pulse only on released->pressed.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            stable_r <= 1'b1;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else begin
            sync1_r <= setButton;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
                press_r  <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign xfer_s = (state_r == ISSUE) && valid_r && cmdReady;

    // Next-state logic and latch enables for the selection sequence.
    always_comb begin
        state_nxt_s = state_r;
        lat_op_s    = 1'b0;
        lat_r1_s    = 1'b0;
        lat_r2_s    = 1'b0;
        bad_s       = 1'b0;
        case (state_r)
            SEL_OP: begin
                if (press_r) begin
                    lat_op_s    = 1'b1;
                    state_nxt_s = SEL_R1;
                end else begin
                    state_nxt_s = SEL_OP;
                end
            end
            SEL_R1: begin
                if (press_r && reg_id_ok(inputs)) begin
                    lat_r1_s    = 1'b1;
                    state_nxt_s = SEL_R2;
                end else if (press_r) begin
                    bad_s = 1'b1;
                end else begin
                    state_nxt_s = SEL_R1;
                end
            end
            SEL_R2: begin
                if (press_r && reg_id_ok(inputs)) begin
                    lat_r2_s    = 1'b1;
                    state_nxt_s = ISSUE;
                end else if (press_r) begin
                    bad_s = 1'b1;
                end else begin
                    state_nxt_s = SEL_R2;
                end
            end
            ISSUE: begin
                if (xfer_s) begin
                    state_nxt_s = WAIT_DONE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT_DONE: begin
                if (opDone) begin
                    state_nxt_s = SEL_OP;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: state_nxt_s = SEL_OP;
        endcase
    end

    // State, command latches and registered status outputs.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_r <= SEL_OP;
            op_r    <= 4'd0;
            r1_r    <= 4'd0;
            r2_r    <= 4'd0;
            valid_r <= 1'b0;
            bad_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (lat_op_s) op_r <= inputs;
            if (lat_r1_s) r1_r <= inputs;
            if (lat_r2_s) r2_r <= inputs;
            // Offer starts one cycle after entering ISSUE and ends at transfer.
            valid_r <= (state_r == ISSUE) && !xfer_s;
            bad_r   <= bad_s;
            busy_r  <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT_DONE);
        end
    end

    assign opCode   = op_r;
    assign regID1   = r1_r;
    assign regID2   = r2_r;
    assign stage    = state_r;
    assign cmdValid = valid_r;
    assign badReg   = bad_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_cmd_entry.sv
// Directed bench for cmd_entry: vector table of button presses plus
// hand-written reset, glitch, backpressure and handshake sequences.
module tb_cmd_entry;

    localparam int D = 4;

    logic       clock;
    logic       resetN;
    logic [3:0] inputs;
    logic       setButton;
    logic [3:0] opCode;
    logic [3:0] regID1;
    logic [3:0] regID2;
    logic [2:0] stage;
    logic       cmdValid;
    logic       cmdReady;
    logic       opDone;
    logic       badReg;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int bad_cnt = 0;
    int valid_cnt = 0;

    typedef struct {
        logic [3:0] sw;
        logic       rdy;
        logic [2:0] st;
        logic [3:0] op;
        logic [3:0] r1;
        logic [3:0] r2;
        int         bad;
    } vec_t;

    vec_t vecs[10];

    cmd_entry #(.DEBOUNCE_CYCLES(D), .REG_COUNT(8)) dut (
        .clock(clock), .resetN(resetN), .inputs(inputs), .setButton(setButton),
        .opCode(opCode), .regID1(regID1), .regID2(regID2), .stage(stage),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .opDone(opDone),
        .badReg(badReg), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse monitors for badReg and cmdValid.
    always @(posedge clock) begin
        if (badReg === 1'b1) bad_cnt++;
        if (cmdValid === 1'b1) valid_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        int b0;
        b0 = bad_cnt;
        @(negedge clock);
        inputs    = vecs[i].sw;
        cmdReady  = vecs[i].rdy;
        setButton = 1'b0;
        repeat (D + 4) @(negedge clock);
        setButton = 1'b1;
        repeat (D + 4) @(negedge clock);
        check($sformatf("v%0d stage", i), 32'(stage), 32'(vecs[i].st));
        check($sformatf("v%0d opCode", i), 32'(opCode), 32'(vecs[i].op));
        check($sformatf("v%0d regID1", i), 32'(regID1), 32'(vecs[i].r1));
        check($sformatf("v%0d regID2", i), 32'(regID2), 32'(vecs[i].r2));
        check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].st >= 3'd3));
        check($sformatf("v%0d badReg pulses", i), 32'(bad_cnt - b0), 32'(vecs[i].bad));
    endtask

    initial begin
        int vbase;
        // sw, rdy, stage, op, r1, r2, badReg pulses
        vecs[0] = '{4'd9,  1'b0, 3'd1, 4'd6, 4'd0, 4'd0, 1};
        vecs[1] = '{4'd15, 1'b0, 3'd1, 4'd6, 4'd0, 4'd0, 1};
        vecs[2] = '{4'd8,  1'b0, 3'd1, 4'd6, 4'd0, 4'd0, 1};
        vecs[3] = '{4'd7,  1'b0, 3'd2, 4'd6, 4'd7, 4'd0, 0};
        vecs[4] = '{4'd12, 1'b0, 3'd2, 4'd6, 4'd7, 4'd0, 1};
        vecs[5] = '{4'd0,  1'b0, 3'd3, 4'd6, 4'd7, 4'd0, 0};
        vecs[6] = '{4'd5,  1'b0, 3'd3, 4'd6, 4'd7, 4'd0, 0};
        vecs[7] = '{4'd1,  1'b1, 3'd1, 4'd1, 4'd7, 4'd0, 0};
        vecs[8] = '{4'd2,  1'b1, 3'd2, 4'd1, 4'd2, 4'd0, 0};
        vecs[9] = '{4'd5,  1'b1, 3'd4, 4'd1, 4'd2, 4'd5, 0};

        // Reset with the button held down.
        resetN = 1'b0; setButton = 1'b0; inputs = 4'd4; cmdReady = 1'b0; opDone = 1'b0;
        repeat (2) @(negedge clock);
        check("rst stage", 32'(stage), 32'd0);
        check("rst opCode", 32'(opCode), 32'd0);
        check("rst regID1", 32'(regID1), 32'd0);
        check("rst regID2", 32'(regID2), 32'd0);
        check("rst cmdValid", 32'(cmdValid), 32'd0);
        check("rst badReg", 32'(badReg), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        resetN = 1'b1;
        repeat (D + 2) @(negedge clock);
        check("post-rst early stage", 32'(stage), 32'd0);
        @(negedge clock);
        check("post-rst latency stage", 32'(stage), 32'd1);
        check("post-rst latency opCode", 32'(opCode), 32'd4);
        setButton = 1'b1;
        repeat (D + 4) @(negedge clock);

        resetN = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        check("rst2 opCode", 32'(opCode), 32'd0);

        // Short glitch, then a press timed to the edge.
        inputs = 4'd6; setButton = 1'b0;
        repeat (3) @(negedge clock);
        setButton = 1'b1;
        repeat (10) @(negedge clock);
        check("glitch stage", 32'(stage), 32'd0);
        check("glitch opCode", 32'(opCode), 32'd0);
        setButton = 1'b0;
        repeat (D + 2) @(negedge clock);
        check("edge k+5 opCode", 32'(opCode), 32'd0);
        @(negedge clock);
        check("edge k+6 opCode", 32'(opCode), 32'd6);
        check("edge k+6 stage", 32'(stage), 32'd1);
        setButton = 1'b1;
        repeat (D + 4) @(negedge clock);

        for (int i = 0; i < 7; i++) apply_vec(i);

        // Backpressure: held offer, presses and opDone ignored.
        setButton = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("bp%0d cmdValid", c), 32'(cmdValid), 32'd1);
            check($sformatf("bp%0d stage", c), 32'(stage), 32'd3);
            check($sformatf("bp%0d cmd", c), {20'd0, opCode, regID1, regID2}, 32'h670);
        end
        setButton = 1'b1;
        opDone = 1'b1;
        @(negedge clock);
        opDone = 1'b0;
        check("opDone in ISSUE stage", 32'(stage), 32'd3);
        check("opDone in ISSUE cmdValid", 32'(cmdValid), 32'd1);
        cmdReady = 1'b1;
        @(negedge clock);
        cmdReady = 1'b0;
        check("xfer stage", 32'(stage), 32'd4);
        check("xfer cmdValid", 32'(cmdValid), 32'd0);
        check("xfer busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clock);
        check("wait cmdValid", 32'(cmdValid), 32'd0);
        opDone = 1'b1;
        @(negedge clock);
        opDone = 1'b0;
        check("done stage", 32'(stage), 32'd0);
        check("done busy", 32'(busy), 32'd0);
        repeat (D + 4) @(negedge clock);

        // Full command with the operation unit always ready.
        vbase = valid_cnt;
        for (int i = 7; i < 10; i++) apply_vec(i);
        check("full cmdValid cycles", 32'(valid_cnt - vbase), 32'd1);

        // Reset while waiting for opDone.
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        check("rst-wait stage", 32'(stage), 32'd0);
        check("rst-wait busy", 32'(busy), 32'd0);
        check("rst-wait cmdValid", 32'(cmdValid), 32'd0);
        check("rst-wait cmd", {20'd0, opCode, regID1, regID2}, 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_entry.md
# cmd_entry

Front-end command sequencer for the 8-bit CPU: debounces the set button, walks the user through opcode / first register / second register selection from the four switches, then issues the assembled command to the operation unit over a valid/ready handshake and waits for its done pulse. It sits between the board switches and buttons and the operation/register-update path. It is the initiating side of the command interface that the operation unit responds to.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button level change (board build overrides to 500000); minimum 2.
- REG_COUNT, default 8: number of addressable registers; register IDs >= REG_COUNT are rejected.

Ports:
- clock  in  1  system clock; all state on rising edge.
- resetN  in  1  synchronous, active-low reset.
- inputs  in  4  raw switch value.
- setButton  in  1  raw button, active-low (pressed = 0), asynchronous to clock.
- opCode  out  4  latched opcode.
- regID1  out  4  latched first register ID.
- regID2  out  4  latched second register ID.
- stage  out  3  current state encoding (0..4, see Operation).
- cmdValid  out  1  command offer to operation unit.
- cmdReady  in  1  operation unit accepts command.
- opDone  in  1  one-cycle pulse from operation unit, operation complete.
- badReg  out  1  one-cycle pulse, rejected register ID.
- busy  out  1  high in ISSUE and WAIT_DONE.

## Operation
- Button path: two-flop synchronizer, then debouncer holding a stable level (reset value 1 = released) and a counter. Counter increments while synchronized level differs from stable level, clears when equal. When counter reaches DEBOUNCE_CYCLES-1 while still differing, stable level flips and counter clears. Stable 1->0 transition produces one-cycle internal press pulse; release produces nothing.
- FSM states: SEL_OP=0, SEL_R1=1, SEL_R2=2, ISSUE=3, WAIT_DONE=4.
- SEL_OP + press: opCode <= inputs, -> SEL_R1.
- SEL_R1 + press: if inputs < REG_COUNT then regID1 <= inputs, -> SEL_R2; else badReg pulse, stay, regID1 unchanged.
- SEL_R2 + press: same rule for regID2, -> ISSUE.
- ISSUE: cmdValid = 1. Transfer occurs on the edge where cmdValid && cmdReady; -> WAIT_DONE, cmdValid low the following cycle. cmdValid never drops before transfer; opCode/regID1/regID2 stable while cmdValid high.
- WAIT_DONE: opDone -> SEL_OP.
- Presses in ISSUE/WAIT_DONE are discarded (not queued). opDone outside WAIT_DONE ignored, including in the transfer cycle.
- Latched opCode/regID values persist across commands until overwritten.

## Timing
- Reset (resetN low at edge): stage=0, opCode=regID1=regID2=0, cmdValid=0, badReg=0, busy=0, synchronizer flops=1, stable level=1, counter=0. Reset mid-handshake or mid-debounce abandons everything; no command issued.
- Press latency: if setButton is first sampled low at edge k and stays low, press pulse is high in the cycle after edge k+1+DEBOUNCE_CYCLES; latches/stage update at edge k+2+DEBOUNCE_CYCLES.
- Low glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no press. Bounce during release likewise filtered; a new press needs a fully debounced release first.
- cmdValid rises the cycle after entering ISSUE (registered from stage). cmdReady already high: transfer on first edge with cmdValid high (one cycle of cmdValid).
- badReg and press pulse are exactly one cycle; busy = (stage==3 || stage==4), registered.
- All arithmetic unsigned 4-bit compares; no wrap of stage beyond 4.

## Test plan
- Reset: resetN low 2 cycles with setButton=0 -> all outputs 0, stage=0, no press detected after release of reset until DEBOUNCE_CYCLES+2 cycles of low elapse.
- Full command (DEBOUNCE_CYCLES=4): presses with inputs=1, 2, 5, cmdReady=1 -> opCode=1, regID1=2, regID2=5, cmdValid high exactly 1 cycle, stage=4; opDone pulse -> stage=0.
- Glitch: setButton low for 3 cycles in SEL_OP -> stage stays 0, opCode unchanged; low for 6 cycles -> opCode latched exactly at edge k+6.
- Bad ID: in SEL_R1 press with inputs=9 -> badReg one pulse, stage stays 1, regID1 unchanged; then inputs=7 press -> regID1=7, stage=2.
- Backpressure: cmdReady=0 for 10 cycles in ISSUE -> cmdValid held high, outputs stable, extra presses ignored; cmdReady=1 -> transfer, cmdValid low next cycle; opDone in ISSUE ignored.
- Reset mid-WAIT_DONE: resetN low -> stage=0, busy=0, cmdValid=0 next cycle, latches 0.
